pipelined_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit for the ALU datapath. It is the successor to the fixed 32-bit two-chunk adder. The operand width is split into STAGES equal chunks, and one chunk is resolved per clock with a registered carry between stages. It adds a valid/ready handshake with back-pressure and a full flag set: carry, signed overflow, zero and negative.

---
 rtl/pipelined_addsub.sv | 124 ++++++++++++
 tb/tb_pipelined_addsub.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: WIDTH is split into STAGES chunks, one chunk resolved per clock
// with a registered carry, global stall on output back-pressure, and carry/overflow/zero/negative flags.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CW   = WIDTH / STAGES;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L    = STAGES - 1;

    function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                              input logic ci);
        add_chunk = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
    endfunction

    logic                          stall_s;
    logic [NREG-1:0]               vld_r;
    logic [NREG-1:0]               cy_r;
    logic [NREG-1:0][WIDTH-1:0]    a_r;
    logic [NREG-1:0][WIDTH-1:0]    b_r;
    logic [NREG-1:0][WIDTH-1:0]    sum_r;

    logic [STAGES-1:0]             sv_s;
    logic [STAGES-1:0]             sc_s;
    logic [STAGES-1:0]             co_s;
    logic [STAGES-1:0][WIDTH-1:0]  sa_s;
    logic [STAGES-1:0][WIDTH-1:0]  sb_s;
    logic [STAGES-1:0][WIDTH-1:0]  ss_s;
    logic [STAGES-1:0][WIDTH-1:0]  ns_s;
    logic [STAGES-1:0][CW:0]       t_s;

    // A single global stall freezes every register, so bubbles stay where they are.
    assign stall_s  = out_valid & ~out_ready;
    assign in_ready = ~stall_s;

    // Stage operand selection and per-stage chunk add; stage 0 sees the inverted-b / carry-in prep.
    always_comb begin
        sv_s = '0;
        sc_s = '0;
        co_s = '0;
        sa_s = '0;
        sb_s = '0;
        ss_s = '0;
        ns_s = '0;
        t_s  = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                sv_s[k] = in_valid;
                sa_s[k] = a;
                sb_s[k] = sub ? ~b : b;
                ss_s[k] = '0;
                sc_s[k] = sub;
            end else begin
                sv_s[k] = vld_r[k-1];
                sa_s[k] = a_r[k-1];
                sb_s[k] = b_r[k-1];
                ss_s[k] = sum_r[k-1];
                sc_s[k] = cy_r[k-1];
            end
            t_s[k]                = add_chunk(sa_s[k][k*CW +: CW], sb_s[k][k*CW +: CW], sc_s[k]);
            ns_s[k]               = ss_s[k];
            ns_s[k][k*CW +: CW]   = t_s[k][CW-1:0];
            co_s[k]               = t_s[k][CW];
        end
    end

    // Intermediate pipeline registers (none exist when STAGES is 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            cy_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
        end else if (!stall_s) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                vld_r[k] <= sv_s[k];
                a_r[k]   <= sa_s[k];
                b_r[k]   <= sb_s[k];
                sum_r[k] <= ns_s[k];
                cy_r[k]  <= co_s[k];
            end
        end
    end

    // Final stage: result and flags; data only updates on a valid beat so idle outputs never move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (!stall_s) begin
            out_valid <= sv_s[L];
            if (sv_s[L]) begin
                sum      <= ns_s[L];
                carry    <= co_s[L];
                // a^b^sum at the MSB recovers the carry into the MSB
                overflow <= sa_s[L][WIDTH-1] ^ sb_s[L][WIDTH-1] ^ ns_s[L][WIDTH-1] ^ co_s[L];
                zero     <= (ns_s[L] == '0);
                negative <= ns_s[L][WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 32/2 main instance plus 16/4 and 8/1 latency instances.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        iv0, ir0, sub0, ov0, or0, c0, v0, z0, n0;
    logic [31:0] a0, b0, s0;
    logic        iv1, ir1, sub1, ov1, or1, c1, v1, z1, n1;
    logic [15:0] a1, b1, s1;
    logic        iv2, ir2, sub2, ov2, or2, c2, v2, z2, n2;
    logic [7:0]  a2, b2, s2;

    pipelined_addsub #(.WIDTH(32), .STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .sub(sub0),
        .out_valid(ov0), .out_ready(or0), .sum(s0), .carry(c0), .overflow(v0), .zero(z0),
        .negative(n0));
    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sub1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .overflow(v1), .zero(z1),
        .negative(n1));
    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sub(sub2),
        .out_valid(ov2), .out_ready(or2), .sum(s2), .carry(c2), .overflow(v2), .zero(z2),
        .negative(n2));

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] q0[$];
    logic [19:0] q1[$];
    logic [11:0] q2[$];

    // Directed vectors, expected = {sum, carry, overflow, zero, negative}
    logic [31:0] va[8] = '{32'h0000FFFF, 32'h7FFFFFFF, 32'h00000005, 32'h00000003,
                           32'hFFFFFFFF, 32'h80000000, 32'h00010000, 32'h12345678};
    logic [31:0] vb[8] = '{32'h00000001, 32'h00000001, 32'h00000005, 32'h00000005,
                           32'h00000001, 32'h00000001, 32'h00000001, 32'h11111111};
    logic        vs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [35:0] ve[8] = '{{32'h00010000, 4'b0000}, {32'h80000000, 4'b0101},
                           {32'h00000000, 4'b1010}, {32'hFFFFFFFE, 4'b0001},
                           {32'h00000000, 4'b1010}, {32'h7FFFFFFF, 4'b1100},
                           {32'h0000FFFF, 4'b1000}, {32'h23456789, 4'b0000}};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [35:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [32:0] f;
        logic [31:0] r;
        logic        cy, ov;
        f  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        r  = f[31:0];
        cy = s ? ~f[32] : f[32];
        ov = s ? ((a[31] != b[31]) && (r[31] != a[31])) : ((a[31] == b[31]) && (r[31] != a[31]));
        return {r, cy, ov, (r == 32'd0), r[31]};
    endfunction

    function automatic logic ov_sel(input int w);
        return (w == 0) ? ov0 : ((w == 1) ? ov1 : ov2);
    endfunction

    // Monitor for the main instance: result order, stall hold and idle hold.
    logic [35:0] prev0;
    logic        prev_ok0 = 1'b0, prev_stall0 = 1'b0, prev_ov0 = 1'b0;
    always @(negedge clk) begin
        logic [35:0] cur;
        #2;
        cur = {s0, c0, v0, z0, n0};
        if (!rst_n) begin
            prev_ok0 = 1'b0;
        end else begin
            if (prev_ok0 && prev_stall0) begin
                check("stall_valid", ov0, 1'b1);
                check("stall_hold", cur, prev0);
            end else if (prev_ok0 && !prev_ov0 && !ov0) begin
                check("idle_hold", cur, prev0);
            end
            if (ov0 && or0) begin
                if (q0.size() == 0) check("unexpected_out32", 1'b1, 1'b0);
                else                check("result32", cur, q0.pop_front());
            end
            prev0       = cur;
            prev_ov0    = ov0;
            prev_stall0 = ov0 && !or0;
            prev_ok0    = 1'b1;
        end
    end

    // Monitors for the small instances (consumer always ready).
    always @(negedge clk) begin
        #2;
        if (rst_n && ov1) begin
            if (q1.size() == 0) check("unexpected_out16", 1'b1, 1'b0);
            else                check("result16", {s1, c1, v1, z1, n1}, q1.pop_front());
        end
        if (rst_n && ov2) begin
            if (q2.size() == 0) check("unexpected_out8", 1'b1, 1'b0);
            else                check("result8", {s2, c2, v2, z2, n2}, q2.pop_front());
        end
    end

    // Called just after a negedge; returns 1 time unit after the accepting posedge.
    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [35:0] e);
        int budget = 50;
        iv0 = 1'b1; a0 = a; b0 = b; sub0 = s;
        #1;
        while (!ir0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("accept_bound", ir0, 1'b1);
        q0.push_back(e);
        @(posedge clk);
        #1 iv0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [19:0] e);
        iv1 = 1'b1; a1 = a; b1 = b; sub1 = s;
        #1 check("in_ready16", ir1, 1'b1);
        q1.push_back(e);
        @(posedge clk);
        #1 iv1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [11:0] e);
        iv2 = 1'b1; a2 = a; b2 = b; sub2 = s;
        #1 check("in_ready8", ir2, 1'b1);
        q2.push_back(e);
        @(posedge clk);
        #1 iv2 = 1'b0;
    endtask

    // Cycles from the accept cycle to the first out_valid cycle.
    task automatic lat_check(input int w, input int exp, input string name);
        int n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (ov_sel(w)) break;
            @(posedge clk);
            n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pat;
        logic [31:0] ra[6], rb[6];
        logic        rs[6];
        int          idx, hold;
        logic        used, acc;

        rst_n = 1'b0;
        iv0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; or1 = 1'b1;
        iv2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; or2 = 1'b1;
        #12;
        check("reset_out_valid", ov0, 1'b0);
        check("reset_outputs", {s0, c0, v0, z0, n0}, 36'd0);
        check("reset_in_ready", ir0, 1'b1);
        check("reset_out_valid16", ov1, 1'b0);
        check("reset_out_valid8", ov2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors one at a time, latency 2 each
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send0(va[i], vb[i], vs[i], ve[i]);
            lat_check(0, 2, "latency32");
        end
        repeat (3) @(negedge clk);

        // Back-to-back stream: out_valid in 8 consecutive cycles
        @(negedge clk);
        send0(va[0], vb[0], vs[0], ve[0]);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            pat[i] = ov0;
            if (i < 7) send0(va[i+1], vb[i+1], vs[i+1], ve[i+1]);
            else       @(posedge clk);
        end
        check("stream_pattern", pat, 11'b00111111110);
        repeat (3) @(negedge clk);

        // Back-pressure: consumer stalls 3 cycles once results start
        for (int i = 0; i < 6; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rs[i] = i[0];
        end
        idx = 0; hold = 0; used = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (!used && ov0) begin
                hold = 3;
                used = 1'b1;
            end
            if (hold > 0) begin
                or0 = 1'b0;
                hold--;
            end else begin
                or0 = 1'b1;
            end
            if (idx < 6) begin
                iv0 = 1'b1; a0 = ra[idx]; b0 = rb[idx]; sub0 = rs[idx];
            end else begin
                iv0 = 1'b0;
            end
            #1;
            if (ov0 && !or0) check("in_ready_stall", ir0, 1'b0);
            acc = iv0 && ir0;
            @(posedge clk);
            if (acc) begin
                q0.push_back(model32(ra[idx], rb[idx], rs[idx]));
                idx++;
            end
        end
        or0 = 1'b1;
        iv0 = 1'b0;
        check("stall_seen", used, 1'b1);
        check("bp_all_accepted", idx, 6);
        check("bp_drained", q0.size(), 0);

        // Reset with two beats in flight
        @(negedge clk);
        send0(va[1], vb[1], vs[1], ve[1]);
        @(negedge clk);
        send0(va[7], vb[7], vs[7], ve[7]);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ov0, 1'b0);
        check("midrst_outputs", {s0, c0, v0, z0, n0}, 36'd0);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("postrst_in_ready", ir0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stale_out", ov0, 1'b0);
        end
        @(negedge clk);
        send0(va[0], vb[0], vs[0], ve[0]);
        lat_check(0, 2, "latency32_postrst");

        // WIDTH=16, STAGES=4: latency 4
        @(negedge clk);
        send1(16'h00FF, 16'h0001, 1'b0, {16'h0100, 4'b0000});
        lat_check(1, 4, "latency16");
        @(negedge clk);
        send1(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 4'b1100});
        lat_check(1, 4, "latency16");
        @(negedge clk);
        send1(16'hFFFF, 16'hFFFF, 1'b0, {16'hFFFE, 4'b1001});
        lat_check(1, 4, "latency16");

        // WIDTH=8, STAGES=1: latency 1
        @(negedge clk);
        send2(8'h0F, 8'h01, 1'b0, {8'h10, 4'b0000});
        lat_check(2, 1, "latency8");
        @(negedge clk);
        send2(8'h80, 8'h80, 1'b0, {8'h00, 4'b1110});
        lat_check(2, 1, "latency8");
        @(negedge clk);
        send2(8'h01, 8'h02, 1'b1, {8'hFF, 4'b0001});
        lat_check(2, 1, "latency8");

        repeat (6) @(negedge clk);
        check("final_q32_empty", q0.size(), 0);
        check("final_q16_empty", q1.size(), 0);
        check("final_q8_empty", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
